// File: rtl/uart_time_tx.sv
// Serial 8N1 transmitter: sends a NUM_CHARS-byte payload (char 0 first) plus an
// EOL terminator, one bit per BIT_CLKS cycles of the 1 MHz clock.
`timescale 1ns/1ps
module uart_time_tx #(
  parameter int unsigned BIT_CLKS  = 104,
  parameter int unsigned NUM_CHARS = 6,
  parameter logic [7:0]  EOL_CHAR  = 8'h0D
) (
  input  logic                   clk1mhz,
  input  logic                   reset,
  input  logic                   send,
  input  logic [8*NUM_CHARS-1:0] tx_data,
  output logic                   txd,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned CNT_W  = $clog2(BIT_CLKS);
  localparam int unsigned DATA_W = 8 * NUM_CHARS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [2:0]        bit_idx, bit_idx_nxt;
  logic [2:0]        char_idx, char_idx_nxt;
  logic [DATA_W-1:0] shadow, shadow_nxt;
  logic              txd_nxt, busy_nxt, done_nxt;

  logic [DATA_W-1:0] shifted_c;
  logic [7:0]        cur_byte_c;
  logic [2:0]        bit_idx_inc_c;
  logic              bit_end_c;

  // Byte currently on the wire: payload character, or the terminator last.
  always_comb begin
    shifted_c     = shadow >> {char_idx, 3'b000};
    cur_byte_c    = (char_idx == 3'(NUM_CHARS)) ? EOL_CHAR : shifted_c[7:0];
    bit_idx_inc_c = bit_idx + 3'd1;
    bit_end_c     = (bit_cnt == CNT_W'(BIT_CLKS - 1));
  end

  // Next-state and next-output logic; outputs change on bit boundaries only.
  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_end_c ? '0 : bit_cnt + CNT_W'(1);
    bit_idx_nxt  = bit_idx;
    char_idx_nxt = char_idx;
    shadow_nxt   = shadow;
    txd_nxt      = txd;
    busy_nxt     = busy;
    done_nxt     = 1'b0;

    case (state)
      IDLE: begin
        bit_cnt_nxt = '0;
        txd_nxt     = 1'b1;
        busy_nxt    = 1'b0;
        if (send) begin
          shadow_nxt   = tx_data;
          char_idx_nxt = 3'd0;
          bit_idx_nxt  = 3'd0;
          busy_nxt     = 1'b1;
          txd_nxt      = 1'b0;
          state_nxt    = START;
        end
      end
      START: begin
        if (bit_end_c) begin
          bit_idx_nxt = 3'd0;
          txd_nxt     = cur_byte_c[0];
          state_nxt   = DATA;
        end
      end
      DATA: begin
        if (bit_end_c) begin
          if (bit_idx == 3'd7) begin
            txd_nxt   = 1'b1;
            state_nxt = STOP;
          end else begin
            bit_idx_nxt = bit_idx_inc_c;
            txd_nxt     = cur_byte_c[bit_idx_inc_c];
          end
        end
      end
      STOP: begin
        if (bit_end_c) begin
          if (char_idx < 3'(NUM_CHARS)) begin
            // Next frame starts immediately, no idle gap.
            char_idx_nxt = char_idx + 3'd1;
            txd_nxt      = 1'b0;
            state_nxt    = START;
          end else begin
            txd_nxt   = 1'b1;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        txd_nxt   = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State, counters, shadow payload and registered outputs.
  always_ff @(posedge clk1mhz or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      bit_idx  <= 3'd0;
      char_idx <= 3'd0;
      shadow   <= '0;
      txd      <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      char_idx <= char_idx_nxt;
      shadow   <= shadow_nxt;
      txd      <= txd_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

endmodule

// File: tb/tb_uart_time_tx.sv
// Bench for uart_time_tx: decodes txd at bit centres against hand-computed
// frames and checks busy/done timing, request filtering and async reset.
`timescale 1ns/1ps
module tb_uart_time_tx;

  logic        clk1mhz = 1'b0;
  logic        reset;
  logic        send;
  logic [47:0] tx_data;
  logic        txd, busy, done;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string           name;
    logic [47:0]     payload;
    logic [6:0][7:0] exp;
  } vec_t;

  vec_t vecs[4];

  uart_time_tx dut (
    .clk1mhz (clk1mhz),
    .reset   (reset),
    .send    (send),
    .tx_data (tx_data),
    .txd     (txd),
    .busy    (busy),
    .done    (done)
  );

  always #500 clk1mhz = ~clk1mhz;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One full message. t counts edges after acceptance; sampled on negedges.
  task automatic run_msg(input string name, input logic [47:0] p, input logic [6:0][7:0] exp,
                         input bit hold, input bit ev, input bit pre);
    logic [69:0] bits;
    logic        prev;
    int          frame_err, busy_err, done_err, edge_err;
    bits = '0; prev = 1'b1;
    frame_err = 0; busy_err = 0; done_err = 0; edge_err = 0;
    if (!pre) begin
      @(negedge clk1mhz);
      tx_data = p;
      send    = 1'b1;
    end
    @(posedge clk1mhz);
    for (int t = 0; t <= 7280; t++) begin
      @(negedge clk1mhz);
      if (t == 0) check({name, " accept busy,txd"}, 64'({busy, txd}), 64'h2);
      if (t < 7280 && (t % 104) == 52) bits[t / 104] = txd;
      if (busy !== (t < 7280)) busy_err++;
      if (done !== (t == 7280)) done_err++;
      if (t > 0 && txd !== prev && (t % 104) != 0) edge_err++;
      prev = txd;
      if (t == 7280) check({name, " txd after msg"}, 64'(txd), 64'h1);
      if (t == 0) send = hold;
      if (ev) begin
        if (t == 9)   tx_data = 48'h393939393939;
        if (t == 499) send = 1'b1;
        if (t == 500) send = 1'b0;
      end
    end
    for (int f = 0; f < 7; f++) begin
      check($sformatf("%s byte%0d", name, f), 64'(bits[10*f+1 +: 8]), 64'(exp[f]));
      if (bits[10*f] !== 1'b0 || bits[10*f+9] !== 1'b1) frame_err++;
    end
    check({name, " framing errs"}, 64'(frame_err), 64'h0);
    check({name, " busy errs"}, 64'(busy_err), 64'h0);
    check({name, " done errs"}, 64'(done_err), 64'h0);
    check({name, " misaligned edges"}, 64'(edge_err), 64'h0);
  endtask

  initial begin
    int viol_txd, viol_busy, viol_done, viol, c;

    vecs[0] = '{"123456",  48'h363534333231, {8'h0D, 8'h36, 8'h35, 8'h34, 8'h33, 8'h32, 8'h31}};
    vecs[1] = '{"55aa",    48'hAA55AA55AA55, {8'h0D, 8'hAA, 8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55}};
    vecs[2] = '{"UUU***",  48'h2A2A2A555555, {8'h0D, 8'h2A, 8'h2A, 8'h2A, 8'h55, 8'h55, 8'h55}};
    vecs[3] = '{"00ff",    48'hFF00FF00FF00, {8'h0D, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00}};

    reset = 1'b1; send = 1'b0; tx_data = '0;
    #200 reset = 1'b0;
    #10;
    check("reset txd,busy,done", 64'({txd, busy, done}), 64'h4);
    repeat (3) @(negedge clk1mhz);
    reset = 1'b1;

    // Idle after reset
    viol_txd = 0; viol_busy = 0; viol_done = 0;
    repeat (2000) begin
      @(negedge clk1mhz);
      if (txd !== 1'b1) viol_txd++;
      if (busy !== 1'b0) viol_busy++;
      if (done !== 1'b0) viol_done++;
    end
    check("idle txd viol", 64'(viol_txd), 64'h0);
    check("idle busy viol", 64'(viol_busy), 64'h0);
    check("idle done viol", 64'(viol_done), 64'h0);

    for (int i = 0; i < 4; i++) run_msg(vecs[i].name, vecs[i].payload, vecs[i].exp, 1'b0, 1'b0, 1'b0);

    // Ignored request plus payload change mid-message
    run_msg("ignore", vecs[0].payload, vecs[0].exp, 1'b0, 1'b1, 1'b0);
    viol = 0;
    repeat (2000) begin
      @(negedge clk1mhz);
      if (busy !== 1'b0 || txd !== 1'b1 || done !== 1'b0) viol++;
    end
    check("ignore no 2nd msg", 64'(viol), 64'h0);

    // Back-to-back with send held high
    run_msg("b2b msg1", vecs[2].payload, vecs[2].exp, 1'b1, 1'b0, 1'b0);
    run_msg("b2b msg2", vecs[2].payload, vecs[2].exp, 1'b0, 1'b0, 1'b1);

    // Reset during char 3 data bit 0 (0x34 bit0 = 0)
    @(negedge clk1mhz);
    tx_data = vecs[0].payload;
    send    = 1'b1;
    @(posedge clk1mhz);
    @(negedge clk1mhz);
    send = 1'b0;
    repeat (3276) @(negedge clk1mhz);
    check("pre-reset txd,busy", 64'({txd, busy}), 64'h1);
    #100 reset = 1'b0;
    #1;
    check("async reset txd", 64'(txd), 64'h1);
    check("async reset busy", 64'(busy), 64'h0);
    check("async reset done", 64'(done), 64'h0);
    @(negedge clk1mhz);
    @(negedge clk1mhz);
    reset = 1'b1;
    viol = 0;
    repeat (2000) begin
      @(negedge clk1mhz);
      if (busy !== 1'b0 || txd !== 1'b1 || done !== 1'b0) viol++;
    end
    check("post-reset idle viol", 64'(viol), 64'h0);

    // Fresh message after reset, bounded wait for done
    tx_data = vecs[1].payload;
    send    = 1'b1;
    @(posedge clk1mhz);
    @(negedge clk1mhz);
    send = 1'b0;
    check("restart busy,txd", 64'({busy, txd}), 64'h2);
    c = 0;
    while (done !== 1'b1 && c < 8000) begin
      @(negedge clk1mhz);
      c++;
    end
    check("restart done latency", 64'(c), 64'd7280);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
